// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset/lock supervisor.
//   pll_seq_state_t : supervisor FSM state encoding
//   *_DEF           : default values for the sequencer parameters
//   RELOCK_W        : width of the saturating relock counter
//   max3            : helper used to size the shared cycle counter
package pll_seq_pkg;

    localparam int unsigned PLL_RST_CYCLES_DEF      = 16;
    localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 1000;
    localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 100000;
    localparam int unsigned SYNC_STAGES_DEF         = 2;

    localparam int unsigned RELOCK_W = 8;

    typedef enum logic [1:0] {
        ST_PLL_RESET = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } pll_seq_state_t;

    // Largest of three cycle counts; the counter must reach the biggest one.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous status bit.
//   clk : destination clock
//   rst : synchronous active-high reset, clears the chain to 0
//   d   : asynchronous input
//   q   : synchronized output (last flop of the chain)
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the input through the chain; bit 0 is the metastability catcher.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset and lock supervisor running on the free-running reference clock.
// Pulses the PLL reset, waits for lock (with timeout and retry), qualifies
// the lock for a programmable time, then releases the datapath reset. Loss
// of lock while running re-resets the PLL and counts the event.
//   clk          : board reference clock (also the PLL refclk)
//   rst          : synchronous active-high board reset
//   pll_locked   : PLL locked flag, asynchronous to clk
//   pll_rst      : PLL reset, high resets the PLL
//   sys_rst      : datapath reset, high while the clock is not trusted
//   ready        : high exactly while in RUN
//   relock_count : number of RUN -> PLL_RESET exits, saturating
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
    parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES         = SYNC_STAGES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_locked,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                ready,
    output logic [RELOCK_W-1:0] relock_count
);

    localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                           LOCK_TIMEOUT_CYCLES);
    // Guard against a zero-width counter when every parameter is 1.
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    pll_seq_state_t      state;
    pll_seq_state_t      state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [RELOCK_W-1:0] relock_next;
    logic                locked_s;

    // Only the synchronized lock flag is ever used for decisions.
    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // State, counter and outputs; outputs decode the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_PLL_RESET;
            cnt          <= '0;
            pll_rst      <= 1'b1;
            sys_rst      <= 1'b1;
            ready        <= 1'b0;
            relock_count <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            pll_rst      <= (state_next == ST_PLL_RESET);
            sys_rst      <= (state_next != ST_RUN);
            ready        <= (state_next == ST_RUN);
            relock_count <= relock_next;
        end
    end

    // Next-state logic; the shared counter is cleared on every state entry.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        relock_next = relock_count;

        case (state)
            ST_PLL_RESET: begin
                // Lock flag deliberately ignored while the PLL is held in reset.
                if (cnt == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = ST_PLL_RESET;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            ST_STABLE: begin
                // Any single low sample restarts qualification via WAIT_LOCK.
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (!locked_s) begin
                    state_next = ST_PLL_RESET;
                    cnt_next   = '0;
                    if (relock_count != '1) begin
                        relock_next = relock_count + RELOCK_W'(1);
                    end
                end
            end

            default: begin
                state_next = ST_PLL_RESET;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small cycle parameters.
// Edge numbering: edge 0 is the last edge sampling rst=1; outputs are
// sampled 1 ns after each rising edge.
module tb_pll_reset_sequencer;

    localparam int unsigned T_PLL_RST = 4;
    localparam int unsigned T_STABLE  = 8;
    localparam int unsigned T_TIMEOUT = 20;
    localparam int unsigned T_SYNC    = 2;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] relock_count;

    int n_checks;
    int n_errors;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (T_PLL_RST),
        .LOCK_STABLE_CYCLES  (T_STABLE),
        .LOCK_TIMEOUT_CYCLES (T_TIMEOUT),
        .SYNC_STAGES         (T_SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .relock_count (relock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One edge with rst high; returns just after edge 0.
    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pll_rst"}, 32'(pll_rst), 32'd1);
        check({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
        check({tag, "_ready"},   32'(ready),   32'd0);
        check({tag, "_relock"},  32'(relock_count), 32'd0);
    endtask

    // Called in RUN just after an edge d: drop lock, expect the re-reset at
    // d+3 (d+1 + two sync stages), re-lock, expect RUN 13 edges later
    // (4 PLL_RESET + 1 WAIT_LOCK + 8 STABLE).
    task automatic loss_cycle(input int exp_cnt);
        pll_locked = 1'b0;
        tick();
        tick();
        check("loss_hold_sys_rst", 32'(sys_rst), 32'd0);
        tick();
        check("loss_sys_rst", 32'(sys_rst), 32'd1);
        check("loss_pll_rst", 32'(pll_rst), 32'd1);
        check("loss_ready",   32'(ready),   32'd0);
        check("loss_relock",  32'(relock_count), 32'(exp_cnt));
        pll_locked = 1'b1;
        repeat (12) tick();
        check("relock_hold_sys_rst", 32'(sys_rst), 32'd1);
        tick();
        check("relock_ready",   32'(ready),   32'd1);
        check("relock_sys_rst", 32'(sys_rst), 32'd0);
    endtask

    // Absolute time bound so the bench always terminates.
    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish within 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_relock;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(posedge clk);

        // Power-up and clean lock: lock rises before edge 10, release at 20.
        apply_reset();
        check_reset_state("pu_reset");
        for (int e = 1; e <= 22; e++) begin
            tick();
            check("pu_pll_rst", 32'(pll_rst), 32'(e < 4));
            check("pu_sys_rst", 32'(sys_rst), 32'(e < 20));
            check("pu_ready",   32'(ready),   32'(e >= 20));
            if (e == 9) pll_locked = 1'b1;
        end
        check("clean_relock", 32'(relock_count), 32'd0);

        // Timeout: no lock, PLL reset re-pulses for 4 edges every 24 edges.
        pll_locked = 1'b0;
        apply_reset();
        for (int e = 1; e <= 72; e++) begin
            tick();
            check("to_pll_rst", 32'(pll_rst), 32'((e % 24) < 4));
            check("to_sys_rst", 32'(sys_rst), 32'd1);
        end

        // Glitch: STABLE entered at edge 12, one-cycle drop before edge 17
        // restarts qualification so release moves from edge 20 to 28.
        apply_reset();
        for (int e = 1; e <= 28; e++) begin
            tick();
            check("gl_sys_rst", 32'(sys_rst), 32'(e < 28));
            check("gl_ready",   32'(ready),   32'(e >= 28));
            if (e == 9)  pll_locked = 1'b1;
            if (e == 16) pll_locked = 1'b0;
            if (e == 17) pll_locked = 1'b1;
        end

        // Lock loss in RUN, three times.
        loss_cycle(1);
        loss_cycle(2);
        loss_cycle(3);

        // Reset mid-RUN with relock_count = 3: full replay with lock held.
        apply_reset();
        check_reset_state("mid_reset");
        for (int e = 1; e <= 13; e++) begin
            tick();
            check("rp_pll_rst", 32'(pll_rst), 32'(e < 4));
            check("rp_sys_rst", 32'(sys_rst), 32'(e < 13));
            check("rp_ready",   32'(ready),   32'(e >= 13));
        end

        // 300 losses: counter saturates at 255.
        exp_relock = 0;
        for (int i = 0; i < 300; i++) begin
            exp_relock = (exp_relock < 255) ? exp_relock + 1 : 255;
            loss_cycle(exp_relock);
        end
        check("sat_relock", 32'(relock_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
